// File: rtl/apu_issue_queue_if.sv
// ============================================================================
// apu_issue_queue_if : core-side and decoder-side signals of apu_issue_queue
// Revision: 1.0
// ============================================================================
`default_nettype none

interface apu_issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               apu_req_i;
  logic               apu_gnt_o;
  logic [2:0][31:0]   apu_operands_i;
  logic [5:0]         apu_op_i;
  logic [14:0]        apu_flags_i;
  logic               apu_rvalid_o;
  logic               dec_req_o;
  logic               dec_gnt_i;
  logic [2:0][31:0]   dec_operands_o;
  logic [5:0]         dec_op_o;
  logic [14:0]        dec_flags_o;
  logic               dec_rvalid_i;
  logic               flush_i;
  logic [CNT_W-1:0]   occupancy_o;
  logic               busy_o;

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  dec_gnt_i, dec_rvalid_i, flush_i,
    output apu_gnt_o, apu_rvalid_o, dec_req_o, dec_operands_o, dec_op_o,
    output dec_flags_o, occupancy_o, busy_o
  );

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output dec_gnt_i, dec_rvalid_i, flush_i,
    input  apu_gnt_o, apu_rvalid_o, dec_req_o, dec_operands_o, dec_op_o,
    input  dec_flags_o, occupancy_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/apu_issue_queue.sv
// ============================================================================
// apu_issue_queue : in-order APU offload buffer, one instruction in flight
// Optional zero-latency empty-queue bypass: APU_QUEUE_BYPASS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module apu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  apu_issue_queue_if.slave  bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 3 * 32 + 6 + 15;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_inflight;

  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_bypass;
  logic               w_push;
  logic               w_issue;
  logic               w_fifo_pop;

  assign w_in_entry = {bus.apu_operands_i, bus.apu_op_i, bus.apu_flags_i};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));

`ifdef APU_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & ~r_inflight & ~bus.flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  // Outside bypass the grant looks only at registered count and flush.
  assign bus.apu_gnt_o = w_bypass ? bus.dec_gnt_i : (~w_full & ~bus.flush_i);
  assign bus.dec_req_o = w_bypass ? bus.apu_req_i
                                  : (~w_empty & ~r_inflight & ~bus.flush_i);
  assign {bus.dec_operands_o, bus.dec_op_o, bus.dec_flags_o} =
      w_bypass ? w_in_entry : w_head;

  assign w_push     = bus.apu_req_i & bus.apu_gnt_o & ~w_bypass;
  assign w_issue    = bus.dec_req_o & bus.dec_gnt_i;
  assign w_fifo_pop = w_issue & ~w_bypass;

  assign bus.apu_rvalid_o = bus.dec_rvalid_i;
  assign bus.occupancy_o  = r_count;
  assign bus.busy_o       = ~w_empty | r_inflight;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_fifo_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_fifo_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Issue needs ~inflight, so it never coincides with a legal completion.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight <= 1'b1;
    end else if (bus.dec_rvalid_i) begin
      r_inflight <= 1'b0;
    end
  end

  a_rvalid_needs_inflight: assert property (
    @(posedge clk) disable iff (!n_reset) bus.dec_rvalid_i |-> r_inflight
  );

endmodule

`default_nettype wire
